// File: rtl/pulse_acq_sequencer_pkg.sv
// Shared definitions for the ultrasonic shot sequencer.
// Contents: the sequencer state enum, the datapath widths and the clock rate
// the period values are expressed against.
package pulse_acq_pkg;

  localparam int CLK_HZ = 50_000_000;

  localparam int PER_W  = 24;  // period counter / cfg_period (~0.33 s at CLK_HZ)
  localparam int PW_W   = 8;   // cfg_pulse_w
  localparam int DLY_W  = 16;  // cfg_delay
  localparam int LEN_W  = 12;  // cfg_len and samples per window
  localparam int SHOT_W = 8;   // cfg_shots and shot_cnt

  // The phase timer must hold the longest of the pulse, delay and window lengths.
  localparam int TMR_W = (DLY_W > LEN_W) ? ((DLY_W > PW_W) ? DLY_W : PW_W)
                                         : ((LEN_W > PW_W) ? LEN_W : PW_W);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUF,
    PULSE,
    DELAY,
    ACQ,
    HOLDOFF
  } state_e;

endpackage

// File: rtl/pulse_acq_sequencer_if.sv
// Host/front-end signal bundle of the shot sequencer.
// master: host side - drives configuration, start/stop and buffer status,
//         observes trigger, acquisition window and run status.
// slave : the sequencer itself.
interface pulse_acq_sequencer_if;
  import pulse_acq_pkg::*;

  logic [PER_W-1:0]  cfg_period;   // shot period in clocks
  logic [PW_W-1:0]   cfg_pulse_w;  // trigger high time in clocks
  logic [DLY_W-1:0]  cfg_delay;    // trigger fall to first sample, clocks
  logic [LEN_W-1:0]  cfg_len;      // samples per shot
  logic [SHOT_W-1:0] cfg_shots;    // shots per run, 0 = continuous
  logic              start;        // one-cycle run request
  logic              stop;         // one-cycle abort request
  logic              buf_ready;    // capture buffer can take a full shot
  logic              trig_out;     // transducer trigger
  logic              acq_en;       // ADC sample-valid window
  logic              acq_first;    // first sample of window
  logic              acq_last;     // last sample of window
  logic              busy;         // run in progress
  logic              done;         // one-cycle end-of-run pulse
  logic [SHOT_W-1:0] shot_cnt;     // shots completed in current run
  logic              err_overrun;  // sticky: period elapsed before shot finished

  modport master (
    output cfg_period, cfg_pulse_w, cfg_delay, cfg_len, cfg_shots,
    output start, stop, buf_ready,
    input  trig_out, acq_en, acq_first, acq_last, busy, done, shot_cnt, err_overrun
  );

  modport slave (
    input  cfg_period, cfg_pulse_w, cfg_delay, cfg_len, cfg_shots,
    input  start, stop, buf_ready,
    output trig_out, acq_en, acq_first, acq_last, busy, done, shot_cnt, err_overrun
  );

endinterface

// File: rtl/pulse_acq_sequencer_shot_timer.sv
// Loadable down-counter timing the PULSE, DELAY and ACQ phases.
// Ports: clk, rst_n (sync, active-low); load_i/load_val_i load a new count;
// dec_i decrements; zero_o flags a zero count now, zero_next_o flags that the
// count will be zero after the coming edge (lets the parent register
// end-of-phase outputs without an extra cycle of latency).
module shot_timer
  import pulse_acq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             zero_next_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first so that no
  // path through the logic leaves a value held, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o      = (cnt_q == '0);
  assign zero_next_o = (cnt_d == '0);

endmodule

// File: rtl/pulse_acq_sequencer.sv
// Shot sequencer for the ultrasonic front end. Each shot fires the trigger
// for pulse_w clocks, waits delay clocks, then opens an acquisition window of
// len samples; shots repeat every period clocks for cfg_shots shots (0 runs
// until stop). All outputs are registered.
// Ports: clk, rst_n (sync, active-low); bus (slave modport) carrying the
// configuration, start/stop, buf_ready and all sequencer outputs.
module pulse_acq_sequencer
  import pulse_acq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  pulse_acq_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [PER_W-1:0]  period_q, per_q, per_d;
  logic [PW_W-1:0]   pw_q;
  logic [DLY_W-1:0]  dly_q;
  logic [LEN_W-1:0]  len_q;
  logic [SHOT_W-1:0] shots_q, cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d, stop_pend_q, stop_pend_d;
  logic              cfg_ld, done_d, per_hit, stop_now;
  logic              tmr_load, tmr_dec, tmr_zero, tmr_zero_next;
  logic [TMR_W-1:0]  tmr_val;
  logic              trig_q, acq_en_q, acq_first_q, acq_last_q, busy_q, done_q;

  shot_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .dec_i       (tmr_dec),
    .zero_o      (tmr_zero),
    .zero_next_o (tmr_zero_next)
  );

  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    cfg_ld      = 1'b0;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;
    per_hit     = (per_q >= period_q - 1'b1);
    cnt_inc     = cnt_q + 1'b1;
    stop_now    = stop_pend_q | bus.stop;

    // Saturating period counter; it never wraps, so HOLDOFF can always see it.
    if (!per_hit) per_d = per_q + 1'b1;

    // A running shot is never cut short: stop is only remembered, and hitting
    // the period end before the window closes is an overrun.
    if (state_q inside {PULSE, DELAY, ACQ}) begin
      stop_pend_d = stop_now;
      if (per_hit) err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d     = WAIT_BUF;
          cfg_ld      = 1'b1;
          cnt_d       = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      WAIT_BUF: begin
        if (bus.stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.buf_ready) begin
          state_d  = PULSE;
          // The entry cycle already counts as elapsed, which makes HOLDOFF
          // plus WAIT_BUF land the next trigger exactly period clocks later.
          per_d    = PER_W'(1);
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(pw_q - 1'b1);
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (dly_q != '0) begin
            state_d = DELAY;
            tmr_val = TMR_W'(dly_q - 1'b1);
          end else begin
            state_d = ACQ;
            tmr_val = TMR_W'(len_q - 1'b1);
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DELAY: begin
        if (tmr_zero) begin
          state_d  = ACQ;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(len_q - 1'b1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ACQ: begin
        if (tmr_zero) begin
          cnt_d = cnt_inc;
          if (stop_now || (shots_q != '0 && cnt_inc == shots_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = HOLDOFF;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLDOFF: begin
        if (bus.stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (per_hit) begin
          state_d = WAIT_BUF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, including the captured configuration, is cleared by
  // reset so a mid-shot reset leaves no stale shot state behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      per_q       <= '0;
      period_q    <= '0;
      pw_q        <= '0;
      dly_q       <= '0;
      len_q       <= '0;
      shots_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      trig_q      <= 1'b0;
      acq_en_q    <= 1'b0;
      acq_first_q <= 1'b0;
      acq_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      if (cfg_ld) begin
        // Zero lengths are clamped to one clock; a zero delay stays zero and
        // makes PULSE hand straight over to ACQ.
        period_q <= (bus.cfg_period  == '0) ? PER_W'(1) : bus.cfg_period;
        pw_q     <= (bus.cfg_pulse_w == '0) ? PW_W'(1)  : bus.cfg_pulse_w;
        len_q    <= (bus.cfg_len     == '0) ? LEN_W'(1) : bus.cfg_len;
        dly_q    <= bus.cfg_delay;
        shots_q  <= bus.cfg_shots;
      end
      // Outputs are registered from the next state so they line up exactly
      // with the state they describe.
      trig_q      <= (state_d == PULSE);
      acq_en_q    <= (state_d == ACQ);
      acq_first_q <= (state_d == ACQ) && (state_q != ACQ);
      acq_last_q  <= (state_d == ACQ) && tmr_zero_next;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
    end
  end

  assign bus.trig_out    = trig_q;
  assign bus.acq_en      = acq_en_q;
  assign bus.acq_first   = acq_first_q;
  assign bus.acq_last    = acq_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.shot_cnt    = cnt_q;
  assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_pulse_acq_sequencer.sv
`timescale 1ns/1ps
module tb_pulse_acq_sequencer;
  import pulse_acq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  pulse_acq_sequencer_if bus ();

  pulse_acq_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected shot: clamped phase lengths, spacing from previous trigger
  // (0 = not checked) and shot_cnt after the window.
  typedef struct {
    int pw;
    int dly;
    int len;
    int gap;
    int cnt;
  } shot_t;

  typedef struct {
    int cnt;
    int err;
  } run_t;

  shot_t shot_q[$];
  run_t  run_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: shot timing from plain arithmetic on the configuration.
  // A shot lasts S = pulse + delay + len clocks; the next trigger needs at
  // least one HOLDOFF and one WAIT_BUF clock, so a period shorter than S+2
  // is an overrun and shots then run back to back S+2 clocks apart.
  function automatic void plan(input int per, input int pw, input int dly,
                               input int len, input int n);
    int p, w, l, s, over;
    shot_t sh;
    run_t  r;
    p    = (per == 0) ? 1 : per;
    w    = (pw  == 0) ? 1 : pw;
    l    = (len == 0) ? 1 : len;
    s    = w + dly + l;
    over = (s >= p - 1) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      sh.pw  = w;
      sh.dly = dly;
      sh.len = l;
      sh.gap = (i == 0) ? 0 : (over != 0 ? s + 2 : p);
      sh.cnt = (i + 1) % 256;
      shot_q.push_back(sh);
    end
    r.cnt = n % 256;
    r.err = over;
    run_q.push_back(r);
  endfunction

  // ---------------- monitor ----------------
  shot_t cur;
  int    cyc = 0, last_rise = 0, fall_t = 0, hi = 0, alen = 0, fl_bad = 0;
  bit    prev_trig = 0, prev_acq = 0;

  always @(negedge clk) begin
    run_t r;
    cyc++;
    if (!rst_n) begin
      prev_trig = 0;
      prev_acq  = 0;
    end else begin
      if (bus.trig_out && !prev_trig) begin
        check("trig_pending", shot_q.size() > 0, 1);
        if (shot_q.size() > 0) cur = shot_q.pop_front();
        if (cur.gap > 0) check("trig_spacing", cyc - last_rise, cur.gap);
        last_rise = cyc;
        hi = 0;
      end
      if (bus.trig_out) hi++;
      if (!bus.trig_out && prev_trig) begin
        fall_t = cyc;
        check("trig_width", hi, cur.pw);
      end
      if (bus.acq_en && !prev_acq) begin
        check("acq_delay", cyc - fall_t, cur.dly);
        alen   = 0;
        fl_bad = 0;
      end
      if (bus.acq_en) begin
        if (bus.acq_first != (alen == 0)) fl_bad++;
        if (bus.acq_last != (alen == cur.len - 1)) fl_bad++;
        if (bus.trig_out) fl_bad++;
        alen++;
      end else if (bus.acq_first || bus.acq_last) begin
        check("stray_flag", {bus.acq_first, bus.acq_last}, 0);
      end
      if (!bus.acq_en && prev_acq) begin
        check("acq_len", alen, cur.len);
        check("first_last", fl_bad, 0);
        check("shot_cnt", bus.shot_cnt, cur.cnt);
      end
      if (bus.done) begin
        check("done_pending", run_q.size() > 0, 1);
        if (run_q.size() > 0) begin
          r = run_q.pop_front();
          check("run_shots", bus.shot_cnt, r.cnt);
          check("run_err", bus.err_overrun, r.err);
        end
        check("busy_at_done", bus.busy, 0);
      end
      prev_trig = bus.trig_out;
      prev_acq  = bus.acq_en;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int per, input int pw, input int dly,
                         input int len, input int shots);
    bus.cfg_period  = PER_W'(per);
    bus.cfg_pulse_w = PW_W'(pw);
    bus.cfg_delay   = DLY_W'(dly);
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_shots   = SHOT_W'(shots);
  endtask

  task automatic scramble_cfg();
    bus.cfg_period  = PER_W'($urandom);
    bus.cfg_pulse_w = PW_W'($urandom);
    bus.cfg_delay   = DLY_W'($urandom);
    bus.cfg_len     = LEN_W'($urandom);
    bus.cfg_shots   = SHOT_W'($urandom);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    scramble_cfg();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20000; i++) begin
      if (!bus.busy) break;
      bus.start = (i == 3);  // a start while busy must be ignored
      tick();
    end
    bus.start = 1'b0;
    check(name, bus.busy, 0);
    tick();
  endtask

  task automatic wait_acq(input bit level);
    for (int i = 0; i < 5000; i++) begin
      if (bus.acq_en == level) break;
      tick();
    end
  endtask

  task automatic run(input int per, input int pw, input int dly,
                     input int len, input int shots);
    set_cfg(per, pw, dly, len, shots);
    plan(per, pw, dly, len, shots);
    pulse_start();
    wait_idle("run_end");
  endtask

  initial begin
    int trig_seen;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.buf_ready = 1'b1;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("reset_outputs", {bus.trig_out, bus.acq_en, bus.acq_first, bus.acq_last,
                            bus.busy, bus.done, bus.shot_cnt, bus.err_overrun}, 0);
    rst_n = 1'b1;
    tick();

    // Directed: single shot, repetition, overrun, zero len/delay.
    run(100, 5, 10, 8, 1);
    run(50, 3, 2, 4, 3);
    run(20, 5, 10, 8, 3);
    run(30, 2, 0, 0, 1);

    // start together with stop: stop wins.
    set_cfg(40, 2, 2, 2, 1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();
    check("start_stop_busy", bus.busy, 0);

    // Backpressure before the 2nd shot.
    set_cfg(40, 3, 4, 6, 3);
    plan(40, 3, 4, 6, 3);
    shot_q[1].gap = 0;
    pulse_start();
    wait_acq(1'b1);
    wait_acq(1'b0);
    bus.buf_ready = 1'b0;
    trig_seen = 0;
    repeat (30) begin
      tick();
      if (bus.trig_out) trig_seen++;
    end
    check("bp_withheld", trig_seen, 0);
    bus.buf_ready = 1'b1;
    tick();
    check("bp_fire", bus.trig_out, 1);
    wait_idle("bp_end");

    // Stop at cycle 3 of the 2nd window in continuous mode.
    set_cfg(60, 3, 5, 8, 0);
    plan(60, 3, 5, 8, 2);
    pulse_start();
    wait_acq(1'b1);
    wait_acq(1'b0);
    wait_acq(1'b1);
    repeat (3) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    wait_idle("stop_acq_end");

    // Stop during HOLDOFF: IDLE with done on the next edge.
    set_cfg(200, 2, 3, 4, 0);
    plan(200, 2, 3, 4, 1);
    pulse_start();
    wait_acq(1'b1);
    wait_acq(1'b0);
    repeat (5) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_hold_done", bus.done, 1);
    check("stop_hold_busy", bus.busy, 0);
    tick();

    // Randomized runs against the model.
    for (int k = 0; k < 10; k++) begin
      run($urandom_range(0, 60), $urandom_range(0, 6), $urandom_range(0, 12),
          $urandom_range(0, 10), $urandom_range(1, 4));
    end

    // Reset in the middle of a long trigger pulse.
    set_cfg(1000, 200, 5, 5, 1);
    plan(1000, 200, 5, 5, 1);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (bus.trig_out) break;
      tick();
    end
    repeat (3) tick();
    rst_n = 1'b0;
    shot_q.delete();
    run_q.delete();
    tick();
    check("rst_mid_pulse", {bus.trig_out, bus.acq_en, bus.acq_first, bus.acq_last,
                            bus.busy, bus.done, bus.shot_cnt, bus.err_overrun}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    check("shots_left", shot_q.size(), 0);
    check("runs_left", run_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
